sr04_ctrl: RTL and testbench

SR04_CTRL -- requirements
Module: sr04_ctrl

---
 rtl/sr04_ctrl_pkg.sv | 35 +++
 rtl/sr04_ctrl_tick_gen_us.sv | 33 +++
 rtl/sr04_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_sr04_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr04_ctrl_pkg.sv
// Shared constants for the HC-SR04 ultrasonic ranger controller: FSM state
// encoding, the echo-time-to-distance scale and the microsecond tick divisor.
package sr04_ctrl_pkg;

  // FSM state encoding (kept as plain constants so older code can reuse it).
  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_ECHO = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;
  localparam logic [2:0] ST_HOLDOFF   = 3'd5;

  // Round-trip echo time per centimetre of distance, in microseconds.
  localparam int unsigned US_PER_CM = 58;

  // Distance register width and its saturation value.
  localparam int unsigned CM_W   = 9;
  localparam int unsigned CM_MAX = 511;

  localparam int unsigned HZ_PER_MHZ = 1_000_000;

  // Clocks per 1 us tick; never below one so slow clocks still tick.
  function automatic int unsigned tick_div(input int unsigned clk_hz);
    return (clk_hz < HZ_PER_MHZ) ? 1 : clk_hz / HZ_PER_MHZ;
  endfunction

  // Largest of three microsecond limits, used to size the shared us counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sr04_ctrl_tick_gen_us.sv
// Microsecond tick generator: one-cycle pulse every DIV clocks while enabled.
// Disabling the generator returns its phase to zero, so every enabled period
// starts with a full microsecond.
module tick_gen_us #(
  parameter int unsigned DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;

  // Free-running divider, held at zero while disabled.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state always uses non-blocking (<=) so every flop samples
    // the pre-edge values of its neighbours, whatever the statement order.
    if (rst) begin
      cnt_q <= '0;
    end else if (!en || cnt_q == CNT_LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = en && (cnt_q == CNT_LAST);

endmodule

// File: rtl/sr04_ctrl.sv
// HC-SR04 ultrasonic ranger controller. A start edge fires a trigger pulse,
// the echo pulse width is converted to centimetres (58 us per cm), and the
// result or a timeout is reported with a one-cycle strobe. A holdoff period
// separates consecutive measurements.
module sr04_ctrl
  import sr04_ctrl_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned ECHO_TO_US = 30_000,
  parameter int unsigned HOLDOFF_US = 60_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_trig,
  input  logic            echo,
  output logic            trig,
  output logic [CM_W-1:0] dist_cm,
  output logic            dist_valid,
  output logic            timeout_err,
  output logic            busy
);

  localparam int unsigned TICK_DIV = tick_div(CLK_HZ);
  localparam int unsigned US_MAX   = max3(TRIG_US, ECHO_TO_US, HOLDOFF_US);
  localparam int unsigned US_W     = $clog2(US_MAX + 1);

  localparam logic [US_W-1:0] TRIG_LAST    = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0] ECHO_TO_LAST = US_W'(ECHO_TO_US - 1);
  localparam logic [US_W-1:0] HOLDOFF_LAST = US_W'(HOLDOFF_US - 1);
  localparam logic [5:0]      SUB_LAST     = 6'(US_PER_CM - 1);
  localparam logic [CM_W-1:0] CM_TOP       = CM_W'(CM_MAX);

  logic [2:0]      state_q, state_d;
  logic [US_W-1:0] us_cnt_q, us_cnt_d;
  logic [5:0]      sub_q, sub_d;
  logic [CM_W-1:0] cm_q, cm_d;
  logic            done_to;

  logic            echo_meta_q, echo_sync_q;
  logic            start_q, arm_q;
  logic            start_edge;
  logic            tick;

  logic [CM_W-1:0] dist_cm_q;
  logic            dist_valid_q, timeout_err_q;

  tick_gen_us #(.DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != ST_IDLE),
    .tick (tick)
  );

  // Echo synchronizer and start edge detector. arm_q stays low until
  // start_trig has been seen low once, so a request held across reset is
  // not mistaken for a new one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_meta_q <= 1'b0;
      echo_sync_q <= 1'b0;
      start_q     <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      start_q     <= start_trig;
      arm_q       <= arm_q | ~start_trig;
    end
  end

  assign start_edge = start_trig && !start_q && arm_q;

  // Next-state logic: sequencing, us timeout counting and cm accumulation.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d  = state_q;
    us_cnt_d = us_cnt_q;
    sub_d    = sub_q;
    cm_d     = cm_q;
    done_to  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d  = ST_TRIG;
          us_cnt_d = '0;
        end
      end
      ST_TRIG: begin
        if (tick) begin
          if (us_cnt_q == TRIG_LAST) begin
            state_d  = ST_WAIT_ECHO;
            us_cnt_d = '0;
          end else begin
            us_cnt_d = us_cnt_q + 1'b1;
          end
        end
      end
      ST_WAIT_ECHO: begin
        if (echo_sync_q) begin
          state_d  = ST_MEASURE;
          us_cnt_d = '0;
          sub_d    = '0;
          cm_d     = '0;
        end else if (tick) begin
          if (us_cnt_q == ECHO_TO_LAST) begin
            state_d = ST_DONE;
            done_to = 1'b1;
          end else begin
            us_cnt_d = us_cnt_q + 1'b1;
          end
        end
      end
      ST_MEASURE: begin
        if (!echo_sync_q) begin
          state_d = ST_DONE;
        end else if (tick) begin
          if (us_cnt_q == ECHO_TO_LAST) begin
            state_d = ST_DONE;
            done_to = 1'b1;
          end else begin
            us_cnt_d = us_cnt_q + 1'b1;
            if (sub_q == SUB_LAST) begin
              sub_d = '0;
              if (cm_q != CM_TOP) cm_d = cm_q + 1'b1;
            end else begin
              sub_d = sub_q + 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d  = ST_HOLDOFF;
        us_cnt_d = '0;
      end
      ST_HOLDOFF: begin
        if (tick) begin
          if (us_cnt_q == HOLDOFF_LAST) begin
            state_d = ST_IDLE;
          end else begin
            us_cnt_d = us_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and measurement counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      us_cnt_q <= '0;
      sub_q    <= '0;
      cm_q     <= '0;
    end else begin
      state_q  <= state_d;
      us_cnt_q <= us_cnt_d;
      sub_q    <= sub_d;
      cm_q     <= cm_d;
    end
  end

  // Result registers, loaded as DONE is entered so they are valid with the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_valid_q  <= 1'b0;
      dist_cm_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      dist_valid_q <= (state_d == ST_DONE);
      if (state_d == ST_DONE) begin
        dist_cm_q     <= done_to ? '0 : cm_d;
        timeout_err_q <= done_to;
      end
    end
  end

  assign trig        = (state_q == ST_TRIG);
  assign busy        = (state_q != ST_IDLE);
  assign dist_cm     = dist_cm_q;
  assign dist_valid  = dist_valid_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sr04_ctrl.sv
// Self-checking bench for sr04_ctrl. Expected results come from a
// behavioural model (distance = echo width / 58 us, saturating; timeouts
// report 0) held in a scoreboard; a monitor compares every cycle.
module tb_sr04_ctrl;

  localparam int CLK_HZ     = 10_000_000;
  localparam int DIV        = 10;
  localparam int TRIG_US    = 10;
  localparam int ECHO_TO_US = 30_000;
  localparam int HOLDOFF_US = 100;
  localparam int US_CM      = 58;
  localparam int CM_SAT     = 511;

  localparam int M_ECHO  = 0;
  localparam int M_NEVER = 1;
  localparam int M_STUCK = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_trig = 1'b0;
  logic       echo = 1'b0;
  logic       trig;
  logic [8:0] dist_cm;
  logic       dist_valid;
  logic       timeout_err;
  logic       busy;

  sr04_ctrl #(
    .CLK_HZ     (CLK_HZ),
    .TRIG_US    (TRIG_US),
    .ECHO_TO_US (ECHO_TO_US),
    .HOLDOFF_US (HOLDOFF_US)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_trig  (start_trig),
    .echo        (echo),
    .trig        (trig),
    .dist_cm     (dist_cm),
    .dist_valid  (dist_valid),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #50 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  typedef struct {
    int cm;
    int to;
    int lat_lo;
    int lat_hi;
  } exp_t;

  exp_t exp_q[$];

  int start_cyc = 0;
  int exp_trigs = 0;
  int trig_rises = 0;
  int valid_cnt = 0;
  int valid_cyc = 0;
  int cap_cm = 0;
  int cap_to = 0;
  int last_cm = 0;
  int last_to = 0;
  int trig_run = 0;
  bit prev_valid = 0, prev_trig = 0, prev_busy = 0, valid_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int val, input int lo, input int hi);
    tests++;
    if (val < lo || val > hi) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d..%0d (t=%0t)", name, val, lo, hi, $time);
    end
  endtask

  // Reference distance for an echo of w_us microseconds.
  function automatic int model_cm(input int w_us);
    int v;
    v = w_us / US_CM;
    return (v > CM_SAT) ? CM_SAT : v;
  endfunction

  // Per-cycle compare against the scoreboard and the output rules.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst) begin
      check("rst_outputs", {trig, dist_cm, dist_valid, timeout_err, busy}, 0);
      exp_q.delete();
      last_cm = 0;
      last_to = 0;
      trig_run = 0;
      prev_valid = 0;
      prev_trig = 0;
      prev_busy = 0;
    end else begin
      if (dist_valid) begin
        check("valid_one_cycle", prev_valid, 0);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got dist_valid=1 dist_cm=%0d, want no strobe", dist_cm);
        end else begin
          e = exp_q.pop_front();
          check("dist_cm", dist_cm, e.cm);
          check("timeout_err", timeout_err, e.to);
          check_range("latency_cycles", cyc - start_cyc, e.lat_lo, e.lat_hi);
          last_cm = e.cm;
          last_to = e.to;
        end
        cap_cm = dist_cm;
        cap_to = timeout_err;
        valid_cnt++;
        valid_cyc = cyc;
        valid_seen = 1;
      end else begin
        check("hold_dist_cm", dist_cm, last_cm);
        check("hold_timeout_err", timeout_err, last_to);
      end
      if (trig) begin
        check("trig_implies_busy", busy, 1);
        if (!prev_trig) trig_rises++;
        trig_run++;
      end else if (prev_trig) begin
        check("trig_width", trig_run, TRIG_US * DIV);
        trig_run = 0;
      end
      if (prev_busy && !busy && valid_seen)
        check_range("holdoff_cycles", cyc - valid_cyc, (HOLDOFF_US - 1) * DIV, HOLDOFF_US * DIV + 2);
      prev_valid = dist_valid;
      prev_trig = trig;
      prev_busy = busy;
    end
  end

  task automatic wait_valid(input int v0, input int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (valid_cnt != v0) seen = 1;
    end
    if (!seen) check("valid_arrived", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    bit seen;
    seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (!busy) seen = 1;
    end
    if (!seen) check("busy_released", busy, 0);
  endtask

  // One measurement: start pulse of 'hold' cycles, echo d_us later lasting
  // w_us (or never / stuck high). 'poke' adds start edges during MEASURE and
  // HOLDOFF that must be ignored.
  task automatic run_meas(input int d_us, input int w_us, input int mode,
                          input int hold, input bit poke);
    exp_t e;
    int   v0;
    if (mode == M_ECHO) begin
      e.cm = model_cm(w_us);
      e.to = 0;
      e.lat_lo = (d_us + w_us) * DIV;
      e.lat_hi = e.lat_lo + 4;
    end else if (mode == M_NEVER) begin
      e.cm = 0;
      e.to = 1;
      e.lat_lo = (TRIG_US + ECHO_TO_US) * DIV;
      e.lat_hi = (1 + TRIG_US + ECHO_TO_US) * DIV + 3;
    end else begin
      e.cm = 0;
      e.to = 1;
      e.lat_lo = (d_us + ECHO_TO_US - 1) * DIV;
      e.lat_hi = (d_us + ECHO_TO_US + 1) * DIV + 4;
    end
    exp_q.push_back(e);
    exp_trigs++;
    v0 = valid_cnt;
    @(negedge clk);
    start_trig = 1'b1;
    start_cyc = cyc + 1;
    repeat (hold) @(negedge clk);
    start_trig = 1'b0;
    if (mode != M_NEVER) begin
      repeat (d_us * DIV - hold) @(negedge clk);
      echo = 1'b1;
    end
    if (mode == M_ECHO) begin
      if (poke) begin
        repeat (w_us * DIV / 2) @(negedge clk);
        start_trig = 1'b1;
        @(negedge clk);
        start_trig = 1'b0;
        repeat (w_us * DIV - w_us * DIV / 2 - 1) @(negedge clk);
      end else begin
        repeat (w_us * DIV) @(negedge clk);
      end
      echo = 1'b0;
    end
    wait_valid(v0, (1 + TRIG_US + 2 * ECHO_TO_US) * DIV + 100);
    echo = 1'b0;
    if (poke) begin
      repeat (20 * DIV) @(negedge clk);
      start_trig = 1'b1;
      @(negedge clk);
      start_trig = 1'b0;
    end
    wait_idle((HOLDOFF_US + 2) * DIV);
    check("trig_count", trig_rises, exp_trigs);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int d, w, h;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_dist_cm", dist_cm, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);

    run_meas(100, 580, M_ECHO, 1, 0);
    check("pulse_cm_10", cap_cm, 10);
    check("pulse_to_0", cap_to, 0);

    run_meas(100, 1160, M_ECHO, 5 * DIV, 0);
    check("held_cm_20", cap_cm, 20);
    check("held_one_trig", trig_rises, 2);

    run_meas(0, 0, M_NEVER, 1, 0);
    check("never_cm_0", cap_cm, 0);
    check("never_to_1", cap_to, 1);

    run_meas(100, 0, M_STUCK, 1, 0);
    check("stuck_cm_0", cap_cm, 0);
    check("stuck_to_1", cap_to, 1);

    run_meas(100, 870, M_ECHO, 1, 1);
    check("poke_cm_15", cap_cm, 15);
    run_meas(100, 348, M_ECHO, 1, 0);
    check("after_poke_cm_6", cap_cm, 6);

    run_meas(100, 29_900, M_ECHO, 1, 0);
    check("saturate_cm_511", cap_cm, 511);

    // Reset mid-measurement, with start_trig held high through release.
    exp_trigs++;
    @(negedge clk);
    start_trig = 1'b1;
    start_cyc = cyc + 1;
    @(negedge clk);
    start_trig = 1'b0;
    repeat (100 * DIV - 1) @(negedge clk);
    echo = 1'b1;
    repeat (300 * DIV) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    #7;
    rst = 1'b1;
    start_trig = 1'b1;
    #1;
    check("rst_now_trig", trig, 0);
    check("rst_now_cm", dist_cm, 0);
    check("rst_now_valid", dist_valid, 0);
    check("rst_now_to", timeout_err, 0);
    check("rst_now_busy", busy, 0);
    repeat (3) @(negedge clk);
    echo = 1'b0;
    rst = 1'b0;
    repeat (50 * DIV) @(negedge clk);
    check("held_start_after_rst_busy", busy, 0);
    check("held_start_after_rst_trigs", trig_rises, exp_trigs);
    start_trig = 1'b0;
    repeat (5) @(negedge clk);
    run_meas(100, 290, M_ECHO, 1, 0);
    check("post_rst_cm_5", cap_cm, 5);

    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(20, 300);
      w = $urandom_range(1, 1500);
      h = $urandom_range(1, 30);
      run_meas(d, w, M_ECHO, h, 0);
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
